// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
//
// Serial transmit stage placed directly after a show-ahead byte FIFO. When
// transmission is enabled and the FIFO is not empty, it pops one word. It then
// sends that word as UART 8N1: a start bit, DBIT data bits LSB first, and one
// stop bit. Bit timing comes from an internal clocks-per-bit counter.
//
// Handshake: rd is a one-cycle pop strobe. It is asserted only in IDLE, only
// while empty=0, and only while reset is released. In any cycle where
// rd=1 && empty=0, r_data is captured. The FIFO advances its head on the same
// rising edge.
//
// Ports
//   clk          : system clock, rising-edge active
//   reset        : asynchronous reset, active low
//   tx_en        : permits starting a new frame (sampled only in IDLE)
//   empty        : FIFO empty flag
//   r_data       : FIFO head word (valid whenever empty=0)
//   rd           : FIFO pop strobe
//   tx           : serial line, idle high, registered
//   tx_busy      : high while a frame is in START, DATA or STOP
//   tx_done_tick : one-cycle pulse in the last cycle of the stop bit
//   dbg_state_o  : current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain #(
    parameter int DBIT         = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_en,
    input  logic            empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic [1:0]      dbg_state_o
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DBIT > 2) ? $clog2(DBIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DBIT-1:0]   shift_q, shift_d;
    logic [DBIT-1:0]   shift_nx;
    logic              tx_q, tx_d;
    logic              tick_last;

    assign tick_last = (tick_q == TICK_LAST);
    assign shift_nx  = shift_q >> 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is computed from the state being entered. This makes the serial
    // line a flop output that changes exactly on bit boundaries.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        rd           = 1'b0;
        tx_done_tick = 1'b0;
        case (state_q)
            IDLE: begin
                // The reset term keeps the strobe low while reset is held.
                // During that time the FIFO must not be drained into a
                // frozen FSM.
                rd = reset && tx_en && !empty;
                if (rd) begin
                    shift_d = r_data;
                    tick_d  = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick_last) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            DATA: begin
                if (tick_last) begin
                    tick_d  = '0;
                    shift_d = shift_nx;
                    if (bit_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                        tx_d  = shift_nx[0];
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            STOP: begin
                if (tick_last) begin
                    tick_done_block: begin
                        tx_done_tick = 1'b1;
                        tick_d       = '0;
                        tx_d         = 1'b1;
                        state_d      = IDLE;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx          = tx_q;
    assign tx_busy     = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
//
// Drives a queue-based FIFO model into uart_tx_fifo_drain. Every cycle, a
// frame-position reference model checks rd, tx, tx_busy and tx_done_tick.
// A line decoder recovers the bytes and compares them with the popped bytes.
// Table vectors cover the reset/idle corners. Hand sequences cover the
// multi-cycle cases. A random phase follows them.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_drain;

  localparam int DBIT  = 8;
  localparam int CPB   = 16;
  localparam int FRAME = (DBIT + 2) * CPB;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tx_en = 1'b0;
  logic            empty = 1'b1;
  logic [DBIT-1:0] r_data = '0;
  logic            rd, tx, tx_busy, tx_done_tick;
  logic [1:0]      dbg_state;

  logic [DBIT-1:0] fifo_q[$];
  logic [DBIT-1:0] exp_q[$];
  int              pop_log[$];
  int              done_log[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dec_n = 0;

  // reference model: position inside current frame (0 = idle)
  int              m_pos = 0;
  logic [DBIT-1:0] m_byte = '0;
  logic            rd_seen = 1'b0;

  // line decoder
  logic            rx_on = 1'b0;
  int              rx_t = 0;
  logic [DBIT-1:0] rx_byte = '0;

  uart_tx_fifo_drain #(.DBIT(DBIT), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_en        (tx_en),
    .empty        (empty),
    .r_data       (r_data),
    .rd           (rd),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- check helpers ----------------
  task automatic chk(input string nm, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", nm, cyc, act, req);
    end
  endtask

  task automatic chki(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic upd_fifo();
    empty  = (fifo_q.size() == 0);
    r_data = empty ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [DBIT-1:0] b);
    fifo_q.push_back(b);
    upd_fifo();
  endtask

  // Advance one clock. The FIFO pops if rd was high during the cycle that
  // just ended. Inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    upd_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- reference model + scoreboard ----------------
  always @(negedge clk) begin
    logic e_rd, e_tx, e_busy, e_done;
    int   bi;
    cyc++;
    if (!reset) begin
      m_pos  = 0;
      e_rd   = 1'b0;
      e_tx   = 1'b1;
      e_busy = 1'b0;
      e_done = 1'b0;
    end else begin
      e_busy = (m_pos != 0);
      e_done = (m_pos == FRAME);
      e_rd   = (m_pos == 0) && tx_en && !empty;
      if (m_pos == 0) e_tx = 1'b1;
      else begin
        bi = (m_pos - 1) / CPB;          // 0 start, 1..DBIT data, DBIT+1 stop
        if (bi == 0) e_tx = 1'b0;
        else if (bi == DBIT + 1) e_tx = 1'b1;
        else e_tx = m_byte[bi-1];
      end
    end
    chk("rd", rd, e_rd);
    chk("tx", tx, e_tx);
    chk("tx_busy", tx_busy, e_busy);
    chk("tx_done_tick", tx_done_tick, e_done);
    chk("state_nonidle", (dbg_state != 2'd0), e_busy);

    rd_seen = rd;
    if (rd) pop_log.push_back(cyc);
    if (tx_done_tick) done_log.push_back(cyc);

    // decoder: samples each bit at its midpoint
    if (!reset) begin
      rx_on = 1'b0;
      exp_q.delete();
    end else if (!rx_on) begin
      if (tx == 1'b0) begin
        rx_on = 1'b1;
        rx_t  = 0;
      end
    end else begin
      rx_t++;
      if (rx_t >= CPB + CPB / 2 && rx_t < (DBIT + 1) * CPB && (rx_t % CPB) == CPB / 2)
        rx_byte[rx_t / CPB - 1] = tx;
      if (rx_t == (DBIT + 1) * CPB + CPB / 2) begin
        chk("stop_bit", tx, 1'b1);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL decode cyc=%0d got=%02h want=<none>", cyc, rx_byte);
        end else begin
          logic [DBIT-1:0] want;
          want = exp_q.pop_front();
          if (rx_byte !== want) begin
            bad++;
            $display("FAIL decode cyc=%0d got=%02h want=%02h", cyc, rx_byte, want);
          end
        end
        dec_n++;
        rx_on = 1'b0;
      end
    end

    // model advance
    if (reset) begin
      if (m_pos == FRAME) m_pos = 0;
      else if (m_pos != 0) m_pos++;
      else if (e_rd) begin
        m_pos  = 1;
        m_byte = r_data;
        exp_q.push_back(r_data);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic rst_n;
    logic en;
    logic have;
    logic e_rd;
    logic e_tx;
    logic e_busy;
  } vec_t;

  vec_t vecs[5];

  // ---------------- main sequence ----------------
  initial begin
    int n0, d0, k0, p;

    vecs[0] = '{rst_n: 1'b1, en: 1'b0, have: 1'b1, e_rd: 1'b0, e_tx: 1'b1, e_busy: 1'b0};
    vecs[1] = '{rst_n: 1'b1, en: 1'b1, have: 1'b0, e_rd: 1'b0, e_tx: 1'b1, e_busy: 1'b0};
    vecs[2] = '{rst_n: 1'b0, en: 1'b1, have: 1'b1, e_rd: 1'b0, e_tx: 1'b1, e_busy: 1'b0};
    vecs[3] = '{rst_n: 1'b0, en: 1'b1, have: 1'b1, e_rd: 1'b0, e_tx: 1'b1, e_busy: 1'b0};
    vecs[4] = '{rst_n: 1'b1, en: 1'b1, have: 1'b1, e_rd: 1'b1, e_tx: 1'b1, e_busy: 1'b0};

    #2 reset = 1'b0;
    run(3);
    reset = 1'b1;

    // table: reset hold, enable/empty gating, release pops at once
    for (int i = 0; i < 5; i++) begin
      tick();
      reset = vecs[i].rst_n;
      tx_en = vecs[i].en;
      if (vecs[i].have && fifo_q.size() == 0) push(8'h5A);
      if (!vecs[i].have) begin
        fifo_q.delete();
        upd_fifo();
      end
      @(negedge clk);
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].e_rd);
      chk($sformatf("vec%0d_tx", i), tx, vecs[i].e_tx);
      chk($sformatf("vec%0d_busy", i), tx_busy, vecs[i].e_busy);
    end
    run(FRAME + 5);

    // single byte 0xA5: one pop, done pulse FRAME cycles later
    n0 = pop_log.size();
    d0 = done_log.size();
    push(8'hA5);
    run(FRAME + 10);
    chki("a5_pops", pop_log.size() - n0, 1);
    chki("a5_dones", done_log.size() - d0, 1);
    if (pop_log.size() > n0 && done_log.size() > d0)
      chki("a5_done_lat", done_log[d0] - pop_log[n0], FRAME);

    // back-to-back 10, 20, 30 preloaded
    tx_en = 1'b0;
    tick();
    n0 = pop_log.size();
    k0 = dec_n;
    push(8'd10);
    push(8'd20);
    push(8'd30);
    tx_en = 1'b1;
    run(3 * (FRAME + 1) + 20);
    chki("b2b_pops", pop_log.size() - n0, 3);
    chki("b2b_decoded", dec_n - k0, 3);
    if (pop_log.size() >= n0 + 3) begin
      chki("b2b_gap1", pop_log[n0+1] - pop_log[n0], FRAME + 1);
      chki("b2b_gap2", pop_log[n0+2] - pop_log[n0+1], FRAME + 1);
    end

    // tx_en low with data waiting: no pop; raise: pop same cycle
    tx_en = 1'b0;
    push(8'h77);
    n0 = pop_log.size();
    run(500);
    chki("en_low_pops", pop_log.size() - n0, 0);
    chk("en_low_tx", tx, 1'b1);
    tx_en = 1'b1;
    @(negedge clk);
    chk("en_rise_rd", rd, 1'b1);
    run(CPB * 3);
    tx_en = 1'b0;              // mid DATA
    push(8'h11);
    run(FRAME + 40);
    chki("en_drop_pops", pop_log.size() - n0, 1);

    // reset pulse during DATA of 0xFF, then 0x3C goes out cleanly
    fifo_q.delete();
    upd_fifo();
    push(8'hFF);
    push(8'h3C);
    n0 = pop_log.size();
    k0 = dec_n;
    tx_en = 1'b1;
    run(CPB * 3);
    reset = 1'b0;
    #1;
    chk("rst_tx_now", tx, 1'b1);
    chk("rst_busy_now", tx_busy, 1'b0);
    run(3);
    reset = 1'b1;
    p = cyc + 1;               // first cycle after release
    run(FRAME + 20);
    chki("rst_pops", pop_log.size() - n0, 2);
    if (pop_log.size() >= n0 + 2) chki("rst_repop_cyc", pop_log[n0+1], p);
    chki("rst_decoded", dec_n - k0, 1);

    // empty held for 1000 cycles
    n0 = pop_log.size();
    d0 = done_log.size();
    run(1000);
    chki("empty_pops", pop_log.size() - n0, 0);
    chki("empty_dones", done_log.size() - d0, 0);
    chk("empty_tx", tx, 1'b1);

    // random phase
    for (int i = 0; i < 6000; i++) begin
      tick();
      if ($urandom_range(0, 39) == 0 && fifo_q.size() < 4)
        push(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 79) == 0) tx_en = ~tx_en;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 2999) == 0) reset = 1'b0;
    end
    reset = 1'b1;
    tx_en = 1'b0;
    run(FRAME + 20);
    chki("exp_q_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time bound
  initial begin
    #900000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

Serial transmit stage that sits directly downstream of the byte FIFO. Pops one byte whenever the FIFO is non-empty and transmission is enabled, then serializes it as UART 8N1: start bit, DBIT data bits LSB first, one stop bit. Bit timing comes from an internal clocks-per-bit counter, so no external baud tick is needed.

## Interface
- DBIT, 8, data word width; must equal the FIFO word width B.
- CLKS_PER_BIT, 16, clock cycles per serial bit; minimum 2.
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- tx_en  input  1  permits starting a new frame; sampled only in IDLE.
- empty  input  1  FIFO empty flag.
- r_data  input  DBIT  FIFO head word; valid whenever empty=0 (show-ahead).
- rd  output  1  FIFO pop strobe, one cycle per byte.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is in progress (START, DATA, STOP).
- tx_done_tick  output  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- FSM states: IDLE, START, DATA, STOP. Registers: state, tick counter (0..CLKS_PER_BIT-1), bit index (0..DBIT-1), shift register (DBIT).
- IDLE: tx=1. rd = (state==IDLE) && tx_en && !empty, combinational. In a cycle with rd=1, r_data is loaded into the shift register, tick counter cleared, next state START.
- START: tx=0 for CLKS_PER_BIT cycles; on tick==CLKS_PER_BIT-1, clear tick, clear bit index, go to DATA.
- DATA: tx = shift[0]. On tick==CLKS_PER_BIT-1: shift right by one, clear tick; if bit index==DBIT-1 go to STOP, else increment bit index.
- STOP: tx=1 for CLKS_PER_BIT cycles; on tick==CLKS_PER_BIT-1, tx_done_tick=1, go to IDLE.
- tx is registered (driven from state/shift register flops, no combinational glitches).
- tx_en deasserted mid-frame has no effect; current frame completes. It only blocks the next pop.
- rd is never asserted when empty=1 (no underflow); rd never asserted outside IDLE.
- Counter arithmetic: tick counter width clog2(CLKS_PER_BIT); bit index width clog2(DBIT); both compare-and-clear, never free-wrap.

## Timing
- Reset values (asynchronous, immediate on reset=0): state=IDLE, tx=1, rd=0, tx_busy=0, tx_done_tick=0, counters and shift register 0.
- Pop cycle N (rd=1): tx falls at edge ending cycle N; start bit occupies cycles N+1..N+CLKS_PER_BIT.
- Frame length: (DBIT+2)*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle inclusive; 160 cycles at defaults.
- Back-to-back: after STOP, one IDLE cycle (tx=1) in which the next pop occurs; pop-to-pop spacing = (DBIT+2)*CLKS_PER_BIT+1 cycles (161 at defaults).
- empty rising in the same cycle as a pop: that pop is valid (empty sampled combinationally before the FIFO updates).
- Reset asserted mid-frame: frame aborted, tx=1 immediately, popped byte is discarded (not re-fetched). After release, next pop occurs in the first cycle with tx_en=1 and empty=0.
- tx_busy is high from the cycle after the pop through the last stop-bit cycle inclusive.

## Test plan
- Reset: hold reset=0 with empty=0, tx_en=1 -> rd=0, tx=1, tx_busy=0 throughout; release -> rd=1 in the first post-release cycle.
- Single byte 0xA5, CLKS_PER_BIT=16: one rd pulse; tx=0 for 16 cycles, then 1,0,1,0,0,1,0,1 each 16 cycles, then 1 for 16 cycles; tx_done_tick pulses at cycle 160 after the pop.
- Back-to-back 10, 20, 30 pre-loaded in FIFO: three rd pulses spaced exactly 161 cycles; decoded serial stream 0x0A, 0x14, 0x1E; tx_busy low for exactly one cycle between frames.
- tx_en=0 with empty=0: no rd for 500 cycles, tx=1; raise tx_en -> rd the same cycle; drop tx_en during DATA -> frame completes, no further rd.
- Reset pulse (0 for 3 cycles) during DATA of 0xFF: tx=1 immediately; no resume of old byte; next FIFO byte 0x3C transmitted cleanly after release.
- empty held 1 for 1000 cycles: rd never asserted, tx stays 1, tx_done_tick never pulses.
